// File: rtl/calc_key_sequencer.sv
// Keypad sequencer for the 2-digit calculator: debounces key codes, collects A-op-B-equal,
// hands operands to the arithmetic unit with a start/done handshake and drives the display path.
module calc_key_sequencer #(
  parameter int DEBOUNCE     = 4,
  parameter int CALC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_in,
  input  logic        calc_done,
  input  logic [13:0] calc_result,
  input  logic        calc_neg,
  output logic [6:0]  op_a,
  output logic [6:0]  op_b,
  output logic [1:0]  op_sel,
  output logic        calc_start,
  output logic [13:0] disp_bin,
  output logic [2:0]  disp_len,
  output logic        disp_neg,
  output logic        disp_err,
  output logic        busy,
  output logic [3:0]  state_dbg
);
  // Handshake: calc_start is a one-cycle pulse in the first CALC cycle; calc_done is
  // accepted in any later CALC cycle and ignored in every other state.
  localparam int KW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(CALC_TIMEOUT) + 1;

  typedef enum logic [3:0] {
    S_A0, S_A1, S_A2, S_OP, S_B1, S_B2, S_CALC, S_SHOW, S_ERR
  } state_t;

  state_t        state, state_n;
  logic [7:0]    key_q;
  logic [KW-1:0] key_cnt, key_cnt_n;
  logic          armed;
  logic [7:0]    key_s;
  logic          press, is_digit, is_op, is_eq, is_clr;
  logic [6:0]    a, a_n, b, b_n;
  logic [1:0]    sel, sel_n;
  logic [13:0]   res, res_n;
  logic          res_neg, res_neg_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [6:0]    dval;

  function automatic logic [2:0] digits(input logic [13:0] v);
    if (v < 14'd10)        return 3'd1;
    else if (v < 14'd100)  return 3'd2;
    else if (v < 14'd1000) return 3'd3;
    else                   return 3'd4;
  endfunction

  // Unknown codes collapse to "no key" before counting.
  always_comb begin
    key_s     = (key_in <= 8'h0E) ? key_in : 8'hFF;
    key_cnt_n = (key_s != key_q) ? KW'(1)
              : (key_cnt == KW'(DEBOUNCE)) ? key_cnt : key_cnt + 1'b1;
    press     = armed && (key_s != 8'hFF) && (key_cnt_n == KW'(DEBOUNCE));
    is_digit  = press && (key_s <= 8'h09);
    is_op     = press && (key_s >= 8'h0A) && (key_s <= 8'h0C);
    is_eq     = press && (key_s == 8'h0D);
    is_clr    = press && (key_s == 8'h0E);
    dval      = {3'b000, key_s[3:0]};
  end

  always_comb begin
    state_n   = state;
    a_n       = a;
    b_n       = b;
    sel_n     = sel;
    res_n     = res;
    res_neg_n = res_neg;
    tcnt_n    = '0;
    case (state)
      S_A0: if (is_digit) begin a_n = dval; state_n = S_A1; end
      S_A1: begin
        if (is_digit) begin a_n = a * 7'd10 + dval; state_n = S_A2; end
        else if (is_op) begin sel_n = key_s[1:0] - 2'd2; state_n = S_OP; end
      end
      S_A2: if (is_op) begin sel_n = key_s[1:0] - 2'd2; state_n = S_OP; end
      S_OP: begin
        if (is_digit) begin b_n = dval; state_n = S_B1; end
        else if (is_op) sel_n = key_s[1:0] - 2'd2;
      end
      S_B1: begin
        if (is_digit) begin b_n = b * 7'd10 + dval; state_n = S_B2; end
        else if (is_eq) state_n = S_CALC;
      end
      S_B2: if (is_eq) state_n = S_CALC;
      S_CALC: begin
        tcnt_n = tcnt + 1'b1;
        if (tcnt != '0 && calc_done) begin
          res_n     = calc_result;
          res_neg_n = calc_neg;
          state_n   = S_SHOW;
        end else if (tcnt == TW'(CALC_TIMEOUT - 1)) begin
          state_n = S_ERR;
        end
      end
      S_SHOW: begin
        if (is_digit) begin
          a_n = dval; b_n = '0; state_n = S_A1;
        end else if (is_op && !res_neg && res <= 14'd99) begin
          a_n = res[6:0]; b_n = '0; sel_n = key_s[1:0] - 2'd2; state_n = S_OP;
        end
      end
      default: ;
    endcase
    if (is_clr) begin
      state_n = S_A0; a_n = '0; b_n = '0; sel_n = '0;
      res_n = '0; res_neg_n = 1'b0; tcnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_A0; key_q <= '0; key_cnt <= '0; armed <= 1'b1;
      a <= '0; b <= '0; sel <= '0; res <= '0; res_neg <= 1'b0; tcnt <= '0;
    end else begin
      state   <= state_n;
      key_q   <= key_s;
      key_cnt <= key_cnt_n;
      if (press) armed <= 1'b0;
      else if (key_s == 8'hFF && key_cnt_n == KW'(DEBOUNCE)) armed <= 1'b1;
      a <= a_n; b <= b_n; sel <= sel_n;
      res <= res_n; res_neg <= res_neg_n; tcnt <= tcnt_n;
    end
  end

  // CALC is only entered from B1/B2, so showing B there keeps the previous display.
  always_comb begin
    op_a       = a;
    op_b       = b;
    op_sel     = sel;
    busy       = (state == S_CALC);
    calc_start = (state == S_CALC) && (tcnt == '0);
    state_dbg  = state;
    disp_bin   = '0;
    disp_len   = '0;
    disp_neg   = 1'b0;
    disp_err   = 1'b0;
    case (state)
      S_A1, S_A2, S_OP: begin
        disp_bin = {7'b0, a};
        disp_len = (a < 7'd10) ? 3'd1 : 3'd2;
      end
      S_B1, S_B2, S_CALC: begin
        disp_bin = {7'b0, b};
        disp_len = (b < 7'd10) ? 3'd1 : 3'd2;
      end
      S_SHOW: begin
        disp_bin = res;
        disp_len = digits(res);
        disp_neg = res_neg;
      end
      S_ERR: disp_err = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed key sequences, a behavioural calculator model
// checked every cycle, plus literal expectations per scenario.
module tb_calc_key_sequencer;
  localparam int DEB = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  key_in = 8'hFF;
  logic        calc_done = 1'b0;
  logic [13:0] calc_result = '0;
  logic        calc_neg = 1'b0;
  logic [6:0]  op_a, op_b;
  logic [1:0]  op_sel;
  logic        calc_start, disp_neg, disp_err, busy;
  logic [13:0] disp_bin;
  logic [2:0]  disp_len;
  logic [3:0]  state_dbg;

  calc_key_sequencer #(.DEBOUNCE(DEB), .CALC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .calc_done(calc_done),
    .calc_result(calc_result), .calc_neg(calc_neg), .op_a(op_a), .op_b(op_b),
    .op_sel(op_sel), .calc_start(calc_start), .disp_bin(disp_bin), .disp_len(disp_len),
    .disp_neg(disp_neg), .disp_err(disp_err), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = entering A, 1 = operator chosen / entering B, 2 = calculating,
  // 3 = showing result, 4 = error. Digit counts track how much of each operand was typed.
  logic [7:0] hist[$];
  bit m_armed = 1;
  int m_phase = 0, m_a = 0, m_b = 0, m_ad = 0, m_bd = 0, m_sel = 0;
  int m_res = 0, m_neg = 0, m_cyc = 0;

  function automatic int lenof(input int v);
    return (v < 10) ? 1 : (v < 100) ? 2 : (v < 1000) ? 3 : 4;
  endfunction

  task automatic m_clear();
    m_phase = 0; m_a = 0; m_b = 0; m_ad = 0; m_bd = 0; m_sel = 0;
    m_res = 0; m_neg = 0; m_cyc = 0;
  endtask

  task automatic m_key(input int k);
    bit dig, op;
    dig = (k <= 9);
    op  = (k >= 10 && k <= 12);
    case (m_phase)
      0: begin
        if (dig && m_ad < 2) begin m_a = m_a * 10 + k; m_ad++; end
        else if (op && m_ad > 0) begin m_sel = k - 10; m_phase = 1; m_bd = 0; end
      end
      1: begin
        if (dig && m_bd < 2) begin m_b = m_b * 10 + k; m_bd++; end
        else if (op && m_bd == 0) m_sel = k - 10;
        else if (k == 13 && m_bd > 0) begin m_phase = 2; m_cyc = 0; end
      end
      3: begin
        if (dig) begin m_a = k; m_ad = 1; m_b = 0; m_bd = 0; m_phase = 0; end
        else if (op && m_neg == 0 && m_res <= 99) begin
          m_a = m_res; m_ad = 2; m_b = 0; m_bd = 0; m_sel = k - 10; m_phase = 1;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin : model
    logic [7:0] s;
    bit same, ev;
    if (!rst) begin
      hist.delete();
      m_armed = 1;
      m_clear();
    end else begin
      s = (key_in <= 8'h0E) ? key_in : 8'hFF;
      hist.push_back(s);
      if (hist.size() > DEB) void'(hist.pop_front());
      same = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] != s) same = 0;
      ev = 0;
      if (same && s == 8'hFF) m_armed = 1;
      else if (same && m_armed) begin ev = 1; m_armed = 0; end
      if (ev && s == 8'h0E) m_clear();
      else if (m_phase == 2) begin
        if (m_cyc >= 1 && calc_done) begin
          m_res = calc_result; m_neg = calc_neg; m_phase = 3;
        end else if (m_cyc + 1 >= TMO) m_phase = 4;
        m_cyc++;
      end else if (ev) m_key(s);
    end
  end

  int n_starts = 0, busy_run = 0, last_busy_run = 0;

  always @(posedge clk) begin : compare
    int e_bin, e_len, e_neg, e_err;
    #1;
    e_bin = 0; e_len = 0; e_neg = 0; e_err = 0;
    case (m_phase)
      0: if (m_ad > 0) begin e_bin = m_a; e_len = (m_a < 10) ? 1 : 2; end
      1: begin
        if (m_bd == 0) begin e_bin = m_a; e_len = (m_a < 10) ? 1 : 2; end
        else begin e_bin = m_b; e_len = (m_b < 10) ? 1 : 2; end
      end
      2: begin e_bin = m_b; e_len = (m_b < 10) ? 1 : 2; end
      3: begin e_bin = m_res; e_len = lenof(m_res); e_neg = m_neg; end
      default: e_err = 1;
    endcase
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("op_sel", op_sel, m_sel);
    chk("calc_start", calc_start, (m_phase == 2 && m_cyc == 0));
    chk("busy", busy, (m_phase == 2));
    chk("disp_bin", disp_bin, e_bin);
    chk("disp_len", disp_len, e_len);
    chk("disp_neg", disp_neg, e_neg);
    chk("disp_err", disp_err, e_err);
    if (calc_start === 1'b1) n_starts++;
    if (busy === 1'b1) busy_run++;
    else begin
      if (busy_run > 0) last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic press(input logic [7:0] code);
    key_in = code;
    repeat (6) @(negedge clk);
    key_in = 8'hFF;
    repeat (6) @(negedge clk);
  endtask

  task automatic done_pulse(input int r, input bit n);
    int w = 0;
    while (busy !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    chk("busy_wait", busy, 1);
    @(negedge clk);
    calc_done = 1'b1; calc_result = 14'(r); calc_neg = n;
    @(negedge clk);
    calc_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    chk("rst_op_a", op_a, 0);
    chk("rst_len", disp_len, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: 42 * 11
    press(8'h04); press(8'h02); press(8'h0C); press(8'h01); press(8'h01); press(8'h0D);
    chk("t1_op_a", op_a, 42);
    chk("t1_op_b", op_b, 11);
    chk("t1_op_sel", op_sel, 2);
    chk("t1_starts", n_starts, 1);
    done_pulse(462, 0);
    chk("t1_bin", disp_bin, 462);
    chk("t1_len", disp_len, 3);
    chk("t1_neg", disp_neg, 0);

    // 2: bouncing 7 then long hold gives one digit
    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0) ? 8'h07 : 8'hFF;
      @(negedge clk);
    end
    key_in = 8'h07;
    repeat (40) @(negedge clk);
    key_in = 8'hFF;
    repeat (6) @(negedge clk);
    chk("t2_op_a", op_a, 7);
    chk("t2_bin", disp_bin, 7);
    chk("t2_len", disp_len, 1);

    // 3: 3 - 9 = -6, then add ignored
    press(8'h0E); press(8'h03); press(8'h0B); press(8'h09); press(8'h0D);
    done_pulse(6, 1);
    chk("t3_neg", disp_neg, 1);
    chk("t3_len", disp_len, 1);
    press(8'h0A);
    chk("t3_hold_bin", disp_bin, 6);
    chk("t3_hold_neg", disp_neg, 1);
    chk("t3_hold_sel", op_sel, 1);

    // 4: timeout to error, digit ignored, clear
    press(8'h0E); press(8'h01); press(8'h02); press(8'h0A); press(8'h05); press(8'h0D);
    repeat (12) @(negedge clk);
    chk("t4_busy_cycles", last_busy_run, 16);
    chk("t4_err", disp_err, 1);
    press(8'h03);
    chk("t4_err_hold", disp_err, 1);
    press(8'h0E);
    chk("t4_clr_err", disp_err, 0);
    chk("t4_clr_a", op_a, 0);
    chk("t4_clr_len", disp_len, 0);

    // 5: 5 + 3 = 8, then chain * 2
    press(8'h05); press(8'h0A); press(8'h03); press(8'h0D);
    s0 = n_starts;
    done_pulse(8, 0);
    chk("t5_bin", disp_bin, 8);
    press(8'h0C);
    chk("t5_chain_bin", disp_bin, 8);
    chk("t5_chain_len", disp_len, 1);
    press(8'h02); press(8'h0D);
    chk("t5_op_a", op_a, 8);
    chk("t5_op_b", op_b, 2);
    chk("t5_op_sel", op_sel, 2);
    chk("t5_starts", n_starts, s0 + 1);
    done_pulse(16, 0);
    chk("t5_res_len", disp_len, 2);

    // 6: reset during CALC, late done ignored
    press(8'h0E); press(8'h01); press(8'h0A); press(8'h02); press(8'h0D);
    chk("t6_busy", busy, 1);
    s0 = n_starts;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    calc_done = 1'b1; calc_result = 14'd99; calc_neg = 1'b0;
    @(negedge clk);
    calc_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_busy_off", busy, 0);
    chk("t6_bin", disp_bin, 0);
    chk("t6_len", disp_len, 0);
    chk("t6_op_b", op_b, 0);
    chk("t6_starts", n_starts, s0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
